// File: rtl/conv_window_accum.sv
// Sums KERNEL_TAPS signed products per window and emits one saturated pixel per window.
// Optional: define CONV_ACCUM_RELU_EN to clamp negative results to zero after saturation.
module conv_window_accum #(
  parameter int PROD_W      = 18,
  parameter int KERNEL_TAPS = 9,
  parameter int ACC_W       = 22,
  parameter int OUT_W       = 9,
  parameter int TAP_W       = $clog2(KERNEL_TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [OUT_W-1:0]  pix_out,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sat,
  output logic [TAP_W-1:0]  tap_idx
);

  if (KERNEL_TAPS < 2) begin : g_bad_taps
    $error("conv_window_accum: KERNEL_TAPS must be >= 2");
  end
  if (ACC_W < PROD_W + $clog2(KERNEL_TAPS)) begin : g_bad_acc
    $error("conv_window_accum: ACC_W too narrow for KERNEL_TAPS products");
  end

  localparam logic [TAP_W-1:0]       LAST_TAP = TAP_W'(KERNEL_TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic [OUT_W-1:0]        sat_val;
  logic                    sat_flag;
  logic                    last;
  logic                    accept;

  assign last       = (tap_idx == LAST_TAP);
  assign prod_ready = !(last && pix_valid && !pix_ready);
  assign accept     = prod_valid && prod_ready;
  assign prod_ext   = {{(ACC_W - PROD_W){prod_in[PROD_W-1]}}, prod_in};

  // tap 0 starts a fresh window, so the previous window's acc is ignored
  assign sum = ((tap_idx == '0) ? '0 : acc) + prod_ext;

  always_comb begin
    sat_flag = 1'b0;
    sat_val  = sum[OUT_W-1:0];
    if (sum > SAT_MAX) begin
      sat_flag = 1'b1;
      sat_val  = SAT_MAX[OUT_W-1:0];
    end else if (sum < SAT_MIN) begin
      sat_flag = 1'b1;
      sat_val  = SAT_MIN[OUT_W-1:0];
    end
`ifdef CONV_ACCUM_RELU_EN
    if (sat_val[OUT_W-1]) begin
      sat_val = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      tap_idx   <= '0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
      pix_sat   <= 1'b0;
    end else begin
      if (accept) begin
        if (last) begin
          pix_out <= sat_val;
          pix_sat <= sat_flag;
          tap_idx <= '0;
        end else begin
          acc     <= sum;
          tap_idx <= tap_idx + TAP_W'(1);
        end
      end
      // a final-tap accept replaces a result consumed in the same cycle
      if (accept && last) begin
        pix_valid <= 1'b1;
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_accum.sv
// Directed self-checking bench for conv_window_accum; expected values are hand-computed.
module tb_conv_window_accum;

  localparam int PROD_W = 18;
  localparam int TAPS   = 9;
  localparam int OUT_W  = 9;
  localparam int TAP_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [PROD_W-1:0] prod_in;
  logic              prod_valid;
  logic              prod_ready;
  logic [OUT_W-1:0]  pix_out;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sat;
  logic [TAP_W-1:0]  tap_idx;

  int checks = 0;
  int errors = 0;

  conv_window_accum #(
    .PROD_W      (PROD_W),
    .KERNEL_TAPS (TAPS),
    .ACC_W       (22),
    .OUT_W       (OUT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .pix_out    (pix_out),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_sat    (pix_sat),
    .tap_idx    (tap_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one product and returns just after the edge on which it was accepted.
  task automatic send(input int v);
    int n;
    n = 0;
    prod_in    = PROD_W'(v);
    prod_valid = 1'b1;
    while (!prod_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("accept_timeout", 0, 1);
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic send_const(input int v, input int count);
    for (int i = 0; i < count; i++) send(v);
  endtask

  function automatic int pix_s();
    return int'($signed(pix_out));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gap_vals[9] = '{-3, 5, 100, -200, 7, 0, 1, 1, 1};
    rst        = 1'b1;
    prod_in    = '0;
    prod_valid = 1'b0;
    pix_ready  = 1'b1;
    tick();
    tick();
    check("rst_pix_out", pix_s(), 0);
    check("rst_pix_valid", int'(pix_valid), 0);
    check("rst_pix_sat", int'(pix_sat), 0);
    check("rst_tap_idx", int'(tap_idx), 0);
    rst = 1'b0;
    tick();
    check("rst_prod_ready", int'(prod_ready), 1);

    // 9 x 10 -> 90
    send_const(10, 8);
    check("w10_tap8", int'(tap_idx), 8);
    check("w10_not_yet_valid", int'(pix_valid), 0);
    send(10);
    check("w10_valid", int'(pix_valid), 1);
    check("w10_out", pix_s(), 90);
    check("w10_sat", int'(pix_sat), 0);
    check("w10_tap0", int'(tap_idx), 0);
    tick();
    check("w10_consumed", int'(pix_valid), 0);

    // 9 x 64 -> 576 saturates high
    send_const(64, 9);
    check("pos_valid", int'(pix_valid), 1);
    check("pos_out", pix_s(), 255);
    check("pos_sat", int'(pix_sat), 1);

    // 9 x -64 -> -576 saturates low
    send_const(-64, 9);
    check("neg_valid", int'(pix_valid), 1);
`ifdef CONV_ACCUM_RELU_EN
    check("neg_out", pix_s(), 0);
`else
    check("neg_out", pix_s(), -256);
`endif
    check("neg_sat", int'(pix_sat), 1);
    tick();

    // backpressure: window A held while window B accumulates
    pix_ready = 1'b0;
    send_const(1, 9);
    check("bpA_valid", int'(pix_valid), 1);
    check("bpA_out", pix_s(), 9);
    send_const(2, 8);
    check("bpB_tap8", int'(tap_idx), 8);
    prod_in    = PROD_W'(2);
    prod_valid = 1'b1;
    tick();
    check("bpB_stall", int'(prod_ready), 0);
    check("bpB_hold_out", pix_s(), 9);
    check("bpB_hold_valid", int'(pix_valid), 1);
    check("bpB_hold_tap", int'(tap_idx), 8);
    pix_ready = 1'b1;
    #1;
    check("bpB_release", int'(prod_ready), 1);
    tick();
    prod_valid = 1'b0;
    check("bpB_valid", int'(pix_valid), 1);
    check("bpB_out", pix_s(), 18);
    check("bpB_tap0", int'(tap_idx), 0);
    tick();
    check("bpB_consumed", int'(pix_valid), 0);

    // valid gaps across a mixed-sign window -> -88
    for (int i = 0; i < 9; i++) begin
      send(gap_vals[i]);
      if (i < 8) tick();
    end
    check("gap_valid", int'(pix_valid), 1);
`ifdef CONV_ACCUM_RELU_EN
    check("gap_out", pix_s(), 0);
`else
    check("gap_out", pix_s(), -88);
`endif
    check("gap_sat", int'(pix_sat), 0);
    tick();

    // reset mid-window discards the partial sum
    send_const(50, 5);
    check("mid_tap5", int'(tap_idx), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_tap", int'(tap_idx), 0);
    check("mid_rst_out", pix_s(), 0);
    check("mid_rst_valid", int'(pix_valid), 0);
    check("mid_rst_sat", int'(pix_sat), 0);
    send_const(1, 9);
    check("post_rst_out", pix_s(), 9);
    check("post_rst_sat", int'(pix_sat), 0);
    check("post_rst_valid", int'(pix_valid), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
